lcd_stream_monitor: RTL and testbench

//  Receiving end of the parallel LCD pixel stream (RGB888 + HSYNC/VSYNC/DE) that
//  the pixel-stream generator drives to the display board. Taps those signals,

---
 rtl/lcd_stream_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_stream_monitor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_stream_monitor.sv
// LCD pixel-stream monitor: recovers frame/line timing, measures active size, flags bad frames, Avalon-MM readout.
// Optional per-frame CRC-16-CCITT signature is built only when LCD_MON_CRC_EN is defined.
module lcd_stream_monitor #(
    parameter int H_ACTIVE         = 800,
    parameter int V_ACTIVE         = 480,
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_valid,
    input  logic [7:0]  lcd_red,
    input  logic [7:0]  lcd_green,
    input  logic [7:0]  lcd_blue,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic        lcd_de,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        frame_irq
);

    localparam int               GW        = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]    LOCK_N    = GW'(LOCK_FRAMES);
    localparam logic [11:0]      H_ACT12   = 12'(H_ACTIVE);
    localparam logic [11:0]      V_ACT12   = 12'(V_ACTIVE);
    localparam logic [11:0]      CNT_MAX   = 12'hFFF;

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

    lock_state_e   state_q, state_d;
    logic          vs_act_q, de_q, hsync_q, seen_q;
    logic [11:0]   pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [11:0]   width_q, width_d, height_q, height_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic          frame_bad_q, frame_bad_d, err_sticky_q, err_sticky_d;
    logic [GW-1:0] good_run_q, good_run_d;
    logic          irq_q;
    logic [31:0]   readdata_q, readdata_d;
    logic [15:0]   crc_rd;

    logic vs_act, frame_start, line_start, line_end, latch, line_bad, bad_now;
    logic clr_cnt, clr_sticky;

    assign vs_act      = (VSYNC_ACTIVE_LOW != 0) ? ~lcd_vsync : lcd_vsync;
    assign frame_start = pix_valid && vs_act && !vs_act_q;
    assign line_start  = pix_valid && lcd_de && !de_q;
    assign line_end    = pix_valid && !lcd_de && de_q;
    // The first frame start after reset only arms the monitor; its partial frame is never reported.
    assign latch       = frame_start && seen_q;
    assign line_bad    = line_end && (pix_cnt_q != H_ACT12);
    assign bad_now     = frame_bad_q || line_bad || (line_cnt_q != V_ACT12);
    assign clr_cnt     = avs_write && (avs_address == 2'd0) && avs_writedata[0];
    assign clr_sticky  = avs_write && (avs_address == 2'd0) && avs_writedata[1];

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        frame_bad_d  = frame_bad_q;
        width_d      = width_q;
        height_d     = height_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        good_run_d   = good_run_q;
        state_d      = state_q;

        if (line_start)
            pix_cnt_d = 12'd1;
        else if (pix_valid && lcd_de && pix_cnt_q != CNT_MAX)
            pix_cnt_d = pix_cnt_q + 12'd1;

        if (frame_start)
            line_cnt_d = {11'd0, line_start};
        else if (line_start && line_cnt_q != CNT_MAX)
            line_cnt_d = line_cnt_q + 12'd1;

        if (line_bad)
            frame_bad_d = 1'b1;
        if (frame_start)
            frame_bad_d = lcd_de;

        if (latch) begin
            width_d     = pix_cnt_q;
            height_d    = line_cnt_q;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (bad_now) begin
                if (err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
                err_sticky_d = 1'b1;
                good_run_d   = '0;
                state_d      = UNLOCKED;
            end else begin
                if (good_run_q != LOCK_N)
                    good_run_d = good_run_q + 1'b1;
                if (good_run_d == LOCK_N)
                    state_d = LOCKED;
            end
        end

        // A host clear in the same cycle as a frame latch overrides the cleared fields.
        if (clr_sticky)
            err_sticky_d = 1'b0;
        if (clr_cnt) begin
            frame_cnt_d = '0;
            err_cnt_d   = '0;
            good_run_d  = '0;
            state_d     = UNLOCKED;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            unique case (avs_address)
                2'd0:    readdata_d = {frame_cnt_q, 13'd0, hsync_q, err_sticky_q, state_q == LOCKED};
                2'd1:    readdata_d = {4'd0, height_q, 4'd0, width_q};
                2'd2:    readdata_d = {16'd0, err_cnt_q};
                default: readdata_d = {16'd0, crc_rd};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= UNLOCKED;
            vs_act_q     <= 1'b0;
            de_q         <= 1'b0;
            hsync_q      <= 1'b0;
            seen_q       <= 1'b0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            width_q      <= '0;
            height_q     <= '0;
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            frame_bad_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            good_run_q   <= '0;
            irq_q        <= 1'b0;
            readdata_q   <= '0;
        end else begin
            if (pix_valid) begin
                vs_act_q <= vs_act;
                de_q     <= lcd_de;
                hsync_q  <= lcd_hsync;
            end
            seen_q       <= seen_q || frame_start;
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            width_q      <= width_d;
            height_q     <= height_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            frame_bad_q  <= frame_bad_d;
            err_sticky_q <= err_sticky_d;
            good_run_q   <= good_run_d;
            irq_q        <= latch;
            readdata_q   <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign frame_irq    = irq_q;

`ifdef LCD_MON_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d, crc_base, crc_lat_q, pix_word;

    // CRC-16-CCITT, polynomial 0x1021, one 16-bit word shifted in MSB first.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign pix_word = {lcd_red[7:3], lcd_green[7:2], lcd_blue[7:3]};

    always_comb begin
        crc_base  = frame_start ? 16'hFFFF : crc_acc_q;
        crc_acc_d = crc_base;
        if (pix_valid && lcd_de)
            crc_acc_d = crc16_word(crc_base, pix_word);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_acc_q <= 16'hFFFF;
            crc_lat_q <= '0;
        end else begin
            crc_acc_q <= crc_acc_d;
            if (latch)
                crc_lat_q <= crc_acc_q;
        end
    end

    assign crc_rd = crc_lat_q;

    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:2], lcd_red[2:0], lcd_green[1:0], lcd_blue[2:0]};
`else
    assign crc_rd = '0;

    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:2], lcd_red, lcd_green, lcd_blue};
`endif

endmodule

// File: tb/tb_lcd_stream_monitor.sv
// Randomized bench for lcd_stream_monitor (H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2) against a frame-level reference model.
module tb_lcd_stream_monitor;

    localparam int H = 8;
    localparam int V = 4;
    localparam int LOCK = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  lcd_red = '0, lcd_green = '0, lcd_blue = '0;
    logic        lcd_hsync = 1'b0, lcd_vsync = 1'b1, lcd_de = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        frame_irq;

    lcd_stream_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LOCK)) dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid),
        .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int irq_seen = 0;

    always @(negedge clk) if (frame_irq) irq_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: frame-level bookkeeping straight from the monitor's rules.
    int m_seen, m_lines, m_last, m_bad, m_crc;
    int m_width, m_height, m_crc_l, m_fcnt, m_err, m_sticky, m_grun, m_locked, m_hs;
    int irq_exp = 0;

    function automatic int crc_word(input int crc_in, input int w);
        int crc = crc_in;
        for (int b = 15; b >= 0; b--) begin
            int top = (crc >> 15) & 1;
            int bt  = (w >> b) & 1;
            crc = (crc << 1) & 32'hFFFF;
            if (top != bt) crc = crc ^ 32'h1021;
        end
        return crc;
    endfunction

    task automatic model_reset();
        m_seen = 0; m_lines = 0; m_last = 0; m_bad = 0; m_crc = 32'hFFFF;
        m_width = 0; m_height = 0; m_crc_l = 0; m_fcnt = 0; m_err = 0;
        m_sticky = 0; m_grun = 0; m_locked = 0; m_hs = 0;
    endtask

    task automatic model_frame_start();
        if (m_seen != 0) begin
            int bad = (m_bad != 0 || m_lines != V) ? 1 : 0;
            m_width = m_last; m_height = m_lines; m_crc_l = m_crc;
            m_fcnt = (m_fcnt + 1) & 32'hFFFF;
            if (bad != 0) begin
                if (m_err < 32'hFFFF) m_err++;
                m_sticky = 1; m_grun = 0; m_locked = 0;
            end else begin
                if (m_grun < LOCK) m_grun++;
                if (m_grun == LOCK) m_locked = 1;
            end
            irq_exp++;
        end
        m_seen = 1; m_lines = 0; m_bad = 0; m_crc = 32'hFFFF;
    endtask

    task automatic pix(input bit vs_act, input bit de, input logic [7:0] r, g, b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b1;
        lcd_vsync = vs_act ? 1'b0 : 1'b1;
        lcd_de    = de;
        lcd_red   = r; lcd_green = g; lcd_blue = b;
        lcd_hsync = 1'($urandom_range(0, 1));
        m_hs      = int'(lcd_hsync);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic idle_pix(input bit vs_act);
        pix(vs_act, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    task automatic vsync_pulse();
        model_frame_start();
        idle_pix(1'b1); idle_pix(1'b1);
        idle_pix(1'b0); idle_pix(1'b0);
    endtask

    // mode 0: random colours, 1: all zero, 2: all 0xFF
    task automatic send_line(input int n, input int mode);
        for (int p = 0; p < n; p++) begin
            logic [7:0] r, g, b;
            r = (mode == 1) ? 8'h00 : (mode == 2) ? 8'hFF : 8'($urandom_range(0, 255));
            g = (mode == 1) ? 8'h00 : (mode == 2) ? 8'hFF : 8'($urandom_range(0, 255));
            b = (mode == 1) ? 8'h00 : (mode == 2) ? 8'hFF : 8'($urandom_range(0, 255));
            pix(1'b0, 1'b1, r, g, b);
            m_crc = crc_word(m_crc, ((int'(r) >> 3) << 11) | ((int'(g) >> 2) << 5) | (int'(b) >> 3));
        end
        idle_pix(1'b0); idle_pix(1'b0); idle_pix(1'b0);
        m_lines++; m_last = n;
        if (n != H) m_bad = 1;
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input int mode);
        vsync_pulse();
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_line) ? bad_len : H, mode);
        idle_pix(1'b0); idle_pix(1'b0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        if (a == 2'd0) begin
            if (d[1]) m_sticky = 0;
            if (d[0]) begin m_fcnt = 0; m_err = 0; m_grun = 0; m_locked = 0; end
        end
    endtask

    function automatic logic [31:0] exp_crc();
`ifdef LCD_MON_CRC_EN
        return 32'(m_crc_l);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_regs(input string tag);
        logic [31:0] d;
        rd(2'd0, d); check({tag, ".status"}, d, 32'((m_fcnt << 16) | (m_hs << 2) | (m_sticky << 1) | m_locked));
        rd(2'd1, d); check({tag, ".size"},   d, 32'((m_height << 16) | m_width));
        rd(2'd2, d); check({tag, ".errcnt"}, d, 32'(m_err));
        rd(2'd3, d); check({tag, ".crc"},    d, exp_crc());
        check({tag, ".irqs"}, 32'(irq_seen), 32'(irq_exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; pix_valid = 1'b0; lcd_de = 1'b0; lcd_vsync = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [31:0] crc_z, crc_f;
        model_reset();
        do_reset();
        check_regs("reset");

        // Three clean frames: two reported, locked after the second.
        for (int f = 0; f < 3; f++) send_frame(V, -1, 0, 0);
        check_regs("clean3");
        check("clean3.irq_count", 32'(irq_seen), 32'd2);

        // Short second line, then a clean frame to latch it.
        send_frame(V, 1, 7, 0);
        send_frame(V, -1, 0, 0);
        check_regs("short_line");

        // Five-line frame, then clean frames to relock.
        send_frame(5, -1, 0, 0);
        for (int f = 0; f < 3; f++) begin
            send_frame(V, -1, 0, 0);
            check_regs($sformatf("relock%0d", f));
        end

        // Random frame geometries.
        for (int f = 0; f < 5; f++) begin
            int nl = $urandom_range(3, 5);
            send_frame(nl, $urandom_range(0, nl - 1), $urandom_range(7, 9), 0);
            check_regs($sformatf("rand%0d", f));
        end

        // Host clears; writes to other addresses have no effect.
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        check_regs("ignored_wr");
        wr(2'd0, 32'h2);
        check_regs("clr_sticky");
        wr(2'd0, 32'h1);
        check_regs("clr_cnt");

        // Signatures of an all-zero and an all-0xFF frame.
        send_frame(V, -1, 0, 1);
        send_frame(V, -1, 0, 0);
        check_regs("crc_zero");
        rd(2'd3, crc_z);
        send_frame(V, -1, 0, 2);
        send_frame(V, -1, 0, 0);
        check_regs("crc_ff");
        rd(2'd3, crc_f);
`ifdef LCD_MON_CRC_EN
        check("crc_differs", 32'(crc_z != crc_f), 32'd1);
`else
        check("crc_zero_off", crc_z | crc_f, 32'd0);
`endif

        // Reset in the middle of a frame.
        vsync_pulse();
        send_line(H, 0);
        send_line(H, 0);
        do_reset();
        check_regs("midreset");
        send_frame(V, -1, 0, 0);
        check_regs("post_reset1");
        send_frame(V, -1, 0, 0);
        check_regs("post_reset2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
